// File: rtl/alu_ser_pkg.sv
// alu_ser_pkg: shared types and constants for the ALU result serializer.
//   ser_state_e      - frame FSM states
//   bytes_per_word() - number of bytes streamed per result word
//   STATUS_CARRY_BIT - bit position of the carry inside the status byte
package alu_ser_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEND   = 2'd1,
    STATUS = 2'd2,
    DONE   = 2'd3
  } ser_state_e;

  localparam int STATUS_CARRY_BIT = 0;

  function automatic int bytes_per_word(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/alu_result_serializer_fifo.sv
// result_fifo: synchronous FIFO holding whole captured results.
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   wr_en_i, wr_data_i    - write request and data
//   rd_en_i, rd_data_o    - pop request; rd_data_o shows the head (first-word fall-through)
//   full_o, empty_o       - occupancy flags
// A write while full is ignored unless a pop happens in the same cycle.
module result_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      wptr_q, rptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_wr, do_rd;

  assign empty_o   = (wptr_q == rptr_q);
  assign full_o    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_rd     = rd_en_i && !empty_o;
  // A pop in the same cycle frees the slot the write lands in.
  assign do_wr     = wr_en_i && (!full_o || do_rd);
  assign rd_data_o = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_rd) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: contents are only observed behind valid pointers.
  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
  end

endmodule

// File: rtl/alu_result_serializer.sv
// alu_result_serializer: captures each new registered ALU result on the rising
// edge of OUT_VALID, buffers it, and streams it LSB-first as bytes over a
// valid/ready interface, optionally followed by a carry status byte.
// Ports:
//   CLK, RST            - clock, synchronous active-high reset
//   ALU_OUT, CARRY_IN   - registered result word and carry
//   OUT_VALID           - level flag; its rising edge marks a new result
//   TX_DATA, TX_VALID   - byte stream out
//   TX_READY            - downstream accepts the byte
//   BUSY                - buffered data or frame in progress
//   OVERFLOW, CLR_OVF   - sticky dropped-result flag and its clear
module alu_result_serializer
  import alu_ser_pkg::*;
#(
  parameter int OUT_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int SEND_STATUS    = 1
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [OUT_DATA_WIDTH-1:0] ALU_OUT,
  input  logic                      CARRY_IN,
  input  logic                      OUT_VALID,
  output logic [7:0]                TX_DATA,
  output logic                      TX_VALID,
  input  logic                      TX_READY,
  output logic                      BUSY,
  output logic                      OVERFLOW,
  input  logic                      CLR_OVF
);

  localparam int NB = bytes_per_word(OUT_DATA_WIDTH);
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  ser_state_e                state_q, state_d;
  logic [OUT_DATA_WIDTH-1:0] word_q, word_d;
  logic                      carry_q, carry_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic                      ov_q;
  logic                      ovf_q, ovf_d;

  logic                      cap, pop, drop;
  logic                      fifo_full, fifo_empty;
  logic [OUT_DATA_WIDTH:0]   fifo_head;

  assign cap  = OUT_VALID && !ov_q;
  assign drop = cap && fifo_full && !pop;

  result_fifo #(
    .WIDTH (OUT_DATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (CLK),
    .rst_i     (RST),
    .wr_en_i   (cap),
    .wr_data_i ({CARRY_IN, ALU_OUT}),
    .rd_en_i   (pop),
    .rd_data_o (fifo_head),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    pop      = 1'b0;
    TX_VALID = 1'b0;
    TX_DATA  = '0;
    case (state_q)
      // DONE behaves like IDLE but lets the next frame start without a gap cycle.
      IDLE, DONE: begin
        if (!fifo_empty) begin
          pop               = 1'b1;
          {carry_d, word_d} = fifo_head;
          cnt_d             = '0;
          state_d           = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        TX_VALID = 1'b1;
        // Word shifts right per byte, so the current byte is always the low 8 bits.
        TX_DATA  = word_q[7:0];
        if (TX_READY) begin
          word_d = word_q >> 8;
          if (cnt_q == CW'(NB - 1)) state_d = (SEND_STATUS != 0) ? STATUS : DONE;
          else                      cnt_d   = cnt_q + CW'(1);
        end
      end
      STATUS: begin
        TX_VALID                  = 1'b1;
        TX_DATA[STATUS_CARRY_BIT] = carry_q;
        if (TX_READY) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A drop in the same cycle as a clear keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (CLR_OVF) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      word_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      ov_q    <= OUT_VALID;
      ovf_q   <= ovf_d;
    end
  end

  assign BUSY     = !fifo_empty || (state_q != IDLE);
  assign OVERFLOW = ovf_q;

endmodule
